ladybird_program_loader: RTL and testbench
==========================================

# ladybird_program_loader

Boot-time program loader between the host serial byte stream and the instruction-RAM bus arbitrator. It receives a length-prefixed little-endian image one byte at a time from the serial interface's receive side and assembles 32-bit words. It writes the words into instruction RAM through a ladybird bus master port, then releases the core from reset. It replaces bench-driven instruction writing and is the arbitrator's write-side input.

## Interface
- Parameters:
- `ADDR_W`, 32, bus address width.
- `BASE_ADDR`, 0, byte address of the first word written.
- `MAX_WORDS`, 1024, largest accepted image length in words.
- `TIMEOUT`, 100000, maximum idle cycles allowed mid-frame; 0 disables the timeout.
- Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock.
- `arst`  in  1  asynchronous active-high reset.
- `in_valid`  in  1  received byte valid.
- `in_ready`  out  1  loader can accept a byte.
- `in_data`  in  8  received byte.
- `bus_req`  out  1  write request.
- `bus_gnt`  in  1  arbitrator grant.
- `bus_addr`  out  ADDR_W  byte address.
- `bus_data`  out  32  write data.
- `bus_wstrb`  out  4  byte strobes.
- `restart`  in  1  one-cycle pulse that re-arms the loader from DONE or ERROR.
- `core_rst`  out  1  active-high reset to the core.
- `done`  out  1  image fully written.
- `error`  out  1  load aborted.
- `word_cnt`  out  ADDR_W  words written so far.

## Operation
- The frame is a 4-byte word count N, LSB first, followed by N×4 image bytes, each word LSB first.
- A byte is accepted on a clock edge where `in_valid && in_ready`. A byte counter (0..3) selects the shift lane.
- FSM states: LEN, DATA, WRITE, DONE, ERROR.
- **LEN** (`in_ready`=1):
  - Collect 4 bytes into N.
  - After the 4th byte: N=0 → DONE; N>MAX_WORDS → ERROR; otherwise → DATA.
- **DATA** (`in_ready`=1):
  - Collect 4 bytes into the word register.
  - After the 4th byte → WRITE.
- **WRITE** (`in_ready`=0):
  - `bus_req`=1, `bus_wstrb`=4'hF, `bus_addr`=BASE_ADDR+4·`word_cnt`, `bus_data`=assembled word.
  - All four values stay stable until the write completes.
  - The write completes on an edge with `bus_req && bus_gnt`. On completion `word_cnt` increments.
  - Then → DONE if `word_cnt`+1==N, else → DATA.
- **DONE**:
  - `done`=1, `core_rst`=0, `in_ready`=0.
  - Extra input bytes are not accepted (backpressure).
- **ERROR**:
  - `error`=1, `core_rst`=1, `in_ready`=0.
- **restart** (DONE or ERROR only):
  - Returns the FSM to LEN and clears `word_cnt`, the byte counter, `done` and `error`.
  - `core_rst` re-asserts to 1.
  - `restart` is ignored in all other states.
- **Timeout**:
  - In LEN or DATA with the byte counter ≠0, an idle counter increments each cycle that no byte is accepted. It clears on every accepted byte.
  - When the counter reaches TIMEOUT → ERROR.
  - In DATA, a byte counter of 0 means the loader is between words and is also covered: DATA with `word_cnt`<N times out whenever a frame is open.
  - LEN with the byte counter at 0 never times out.
- Address arithmetic wraps modulo 2^ADDR_W. No overflow detection.

## Timing
- Reset values:
  - state LEN, `in_ready`=1.
  - `bus_req`=0, `bus_addr`=BASE_ADDR, `bus_data`=0, `bus_wstrb`=0.
  - `core_rst`=1, `done`=0, `error`=0, `word_cnt`=0.
  - Byte counter and idle counter 0.
- Reset is asynchronous and may assert mid-WRITE. `bus_req` drops immediately with no handshake completion; the arbitrator tolerates request withdrawal on reset.
- The 4th byte of a word is accepted at edge k. `bus_req`=1 from cycle k+1.
- If `bus_gnt` is already high, the write completes at edge k+1 and `in_ready`=1 from cycle k+2.
- Per-word minimum is 5 cycles (4 bytes + 1 write).
- `in_ready`, `done`, `error` and `core_rst` are registered and change only on clock edges, except on reset.
- When the last write completes at edge m: `done`=1 and `core_rst`=0 in cycle m+1.
- The `bus_gnt` wait is unbounded; the timeout counter does not run in WRITE.

## Test plan
- **Basic load.** Bytes 02 00 00 00, FF 0F 10 00, 03 81 00 00 with `bus_gnt` tied 1 → writes 0x00100FFF@0x0, then 0x00008103@0x4. `done`=1, `core_rst`=0, `word_cnt`=2.
- **Grant stall.** Same stream; hold `bus_gnt`=0 for 7 cycles in WRITE → `bus_req`/`addr`/`data` stable throughout, `in_ready`=0, exactly one write when `bus_gnt` rises.
- **Zero and oversize length.** N=0 → `done`=1 the cycle after the 4th byte, no `bus_req`. N=MAX_WORDS+1 → `error`=1, `core_rst` stays 1, no writes.
- **Timeout.** TIMEOUT=16; send 2 data bytes then stop → `error`=1 exactly 16 cycles after the last accepted byte. `restart` pulse → LEN, `error`=0.
- **Reset mid-WRITE.** Assert `arst` while `bus_req`=1 → `bus_req`=0 immediately. After release, a full 1-word load writes to BASE_ADDR.
- **Post-done backpressure and reload.** After `done`, drive `in_valid`=1 for 10 cycles → no byte accepted. `restart`, then a 1-word image 0xDEADBEEF → written at BASE_ADDR, `done` again.

Source files
------------

// File: rtl/ladybird_program_loader.sv
// ladybird_program_loader
// Boot-time program loader. Takes a length-prefixed, little-endian image from
// the serial receive byte stream, packs it into 32-bit words, writes each word
// into instruction RAM through the bus master port and finally lets the core
// out of reset. A restart pulse in DONE or ERROR re-arms it for another image.
module ladybird_program_loader #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       MAX_WORDS = 1024,
    parameter int unsigned       TIMEOUT   = 100000
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_data,
    output logic [3:0]        bus_wstrb,
    input  logic              restart,
    output logic              core_rst,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] word_cnt
);

    // Width used when comparing the written-word count against the 32-bit
    // length field, so neither side is truncated whatever ADDR_W is.
    localparam int unsigned CW = (ADDR_W > 32) ? ADDR_W : 32;

    // Idle count at which the next idle cycle trips the timeout.
    localparam logic [31:0] TIMEOUT_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_LEN,
        ST_DATA,
        ST_WRITE,
        ST_DONE,
        ST_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [31:0]       len_q, len_d;
    logic [31:0]       word_q, word_d;
    logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
    logic [31:0]       idle_q, idle_d;

    logic              in_ready_q, in_ready_d;
    logic              bus_req_q, bus_req_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [31:0]       bus_data_q, bus_data_d;
    logic [3:0]        bus_wstrb_q, bus_wstrb_d;
    logic              core_rst_q, core_rst_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic              accept;
    logic              last_byte;
    logic [31:0]       len_merged;
    logic [31:0]       word_merged;
    logic [ADDR_W-1:0] word_cnt_inc;
    logic              last_word;
    logic              len_zero;
    logic              len_too_big;
    logic              timer_armed;
    logic              timed_out;

    // Datapath helpers: byte acceptance, lane insertion and the compare flags
    // the state machine branches on.
    always_comb begin
        accept       = in_valid && in_ready_q;
        last_byte    = (byte_cnt_q == 2'd3);

        len_merged   = len_q;
        len_merged[{byte_cnt_q, 3'b000} +: 8] = in_data;
        word_merged  = word_q;
        word_merged[{byte_cnt_q, 3'b000} +: 8] = in_data;

        word_cnt_inc = word_cnt_q + ADDR_W'(1);
        last_word    = (CW'(word_cnt_inc) == CW'(len_q));
        len_zero     = (len_merged == 32'd0);
        len_too_big  = (len_merged > MAX_WORDS);

        // A frame is open once the first length byte has arrived; from then
        // on, every cycle without a byte counts toward the timeout.
        timer_armed  = (TIMEOUT != 0) &&
                       (((state_q == ST_LEN) && (byte_cnt_q != 2'd0)) ||
                        (state_q == ST_DATA));
        timed_out    = timer_armed && !accept && (idle_q == TIMEOUT_LAST);
    end

    // Next-state logic: collect the length, collect each word, hand it to the
    // bus, and park in DONE or ERROR until a restart pulse.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        len_d      = len_q;
        word_d     = word_q;
        word_cnt_d = word_cnt_q;
        idle_d     = idle_q;
        bus_data_d = bus_data_q;

        case (state_q)
            ST_LEN: begin
                if (accept) begin
                    len_d      = len_merged;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    idle_d     = 32'd0;
                    if (last_byte) begin
                        if (len_zero) begin
                            state_d = ST_DONE;
                        end else if (len_too_big) begin
                            state_d = ST_ERROR;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end
                end else if (timed_out) begin
                    state_d = ST_ERROR;
                end else if (timer_armed) begin
                    idle_d = idle_q + 32'd1;
                end
            end

            ST_DATA: begin
                if (accept) begin
                    word_d     = word_merged;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    idle_d     = 32'd0;
                    if (last_byte) begin
                        bus_data_d = word_merged;
                        state_d    = ST_WRITE;
                    end
                end else if (timed_out) begin
                    state_d = ST_ERROR;
                end else if (timer_armed) begin
                    idle_d = idle_q + 32'd1;
                end
            end

            ST_WRITE: begin
                // The grant wait is unbounded, so the idle counter is held at
                // zero here and starts fresh for the next word.
                idle_d = 32'd0;
                if (bus_req_q && bus_gnt) begin
                    word_cnt_d = word_cnt_inc;
                    state_d    = last_word ? ST_DONE : ST_DATA;
                end
            end

            ST_DONE, ST_ERROR: begin
                if (restart) begin
                    state_d    = ST_LEN;
                    byte_cnt_d = 2'd0;
                    len_d      = 32'd0;
                    word_cnt_d = '0;
                    idle_d     = 32'd0;
                end
            end

            default: begin
                state_d = ST_ERROR;
            end
        endcase
    end

    // Output values for the next cycle, decoded from the next state so every
    // status and bus output comes straight from a flop.
    always_comb begin
        in_ready_d  = (state_d == ST_LEN) || (state_d == ST_DATA);
        bus_req_d   = (state_d == ST_WRITE);
        bus_wstrb_d = (state_d == ST_WRITE) ? 4'hF : 4'h0;
        bus_addr_d  = BASE_ADDR + (word_cnt_d << 2);
        core_rst_d  = (state_d != ST_DONE);
        done_d      = (state_d == ST_DONE);
        error_d     = (state_d == ST_ERROR);
    end

    // State and output registers; reset drops any outstanding bus request at
    // once and holds the core in reset.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q     <= ST_LEN;
            byte_cnt_q  <= 2'd0;
            len_q       <= 32'd0;
            word_q      <= 32'd0;
            word_cnt_q  <= '0;
            idle_q      <= 32'd0;
            in_ready_q  <= 1'b1;
            bus_req_q   <= 1'b0;
            bus_addr_q  <= BASE_ADDR;
            bus_data_q  <= 32'd0;
            bus_wstrb_q <= 4'h0;
            core_rst_q  <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            len_q       <= len_d;
            word_q      <= word_d;
            word_cnt_q  <= word_cnt_d;
            idle_q      <= idle_d;
            in_ready_q  <= in_ready_d;
            bus_req_q   <= bus_req_d;
            bus_addr_q  <= bus_addr_d;
            bus_data_q  <= bus_data_d;
            bus_wstrb_q <= bus_wstrb_d;
            core_rst_q  <= core_rst_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign bus_req   = bus_req_q;
    assign bus_addr  = bus_addr_q;
    assign bus_data  = bus_data_q;
    assign bus_wstrb = bus_wstrb_q;
    assign core_rst  = core_rst_q;
    assign done      = done_q;
    assign error     = error_q;
    assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_ladybird_program_loader.sv
// Testbench for ladybird_program_loader: directed scenarios plus randomized
// frames, checked every cycle against a frame-level reference model.
module tb_ladybird_program_loader;

    localparam int unsigned TB_ADDR_W = 32;
    localparam logic [31:0] TB_BASE   = 32'h0000_0100;
    localparam int unsigned TB_MAX    = 8;
    localparam int unsigned TB_TO     = 16;

    logic        clk = 1'b0;
    logic        arst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        bus_req;
    logic        bus_gnt;
    logic [31:0] bus_addr;
    logic [31:0] bus_data;
    logic [3:0]  bus_wstrb;
    logic        restart;
    logic        core_rst;
    logic        done;
    logic        error;
    logic [31:0] word_cnt;

    int compared   = 0;
    int mismatched = 0;
    bit chk_en     = 1'b0;
    bit gnt_rand   = 1'b0;
    bit rnd_restart = 1'b0;

    logic [31:0] img[$];
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          acc_cnt = 0;

    always #5 clk = ~clk;

    ladybird_program_loader #(
        .ADDR_W   (TB_ADDR_W),
        .BASE_ADDR(TB_BASE),
        .MAX_WORDS(TB_MAX),
        .TIMEOUT  (TB_TO)
    ) dut (
        .clk      (clk),
        .arst     (arst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .bus_req  (bus_req),
        .bus_gnt  (bus_gnt),
        .bus_addr (bus_addr),
        .bus_data (bus_data),
        .bus_wstrb(bus_wstrb),
        .restart  (restart),
        .core_rst (core_rst),
        .done     (done),
        .error    (error),
        .word_cnt (word_cnt)
    );

    // Frame-level view of the loader: how many frame bytes have arrived, how
    // many words are written, whether a word is waiting for the bus.
    typedef struct packed {
        int          bytes;
        int          words;
        int          idle;
        logic [31:0] len;
        logic [31:0] word;
        logic        pend;
        logic        done;
        logic        err;
        logic        acc;
    } model_t;

    model_t m = '0;

    function automatic model_t modelStep(input model_t s, input logic v, input logic [7:0] d,
                                         input logic g, input logic r);
        model_t n = s;
        int     lane;
        n.acc = 1'b0;
        if (s.done || s.err) begin
            if (r) n = '0;
        end else if (s.pend) begin
            n.idle = 0;
            if (g) begin
                n.pend  = 1'b0;
                n.words = s.words + 1;
                if (n.words == int'(s.len)) n.done = 1'b1;
            end
        end else if (v) begin
            n.acc  = 1'b1;
            n.idle = 0;
            if (s.bytes < 4) begin
                n.len = s.len | (32'(d) << (8 * s.bytes));
            end else begin
                lane   = (s.bytes - 4) % 4;
                n.word = ((lane == 0) ? 32'd0 : s.word) | (32'(d) << (8 * lane));
            end
            n.bytes = s.bytes + 1;
            if (n.bytes == 4) begin
                if (n.len == 32'd0) n.done = 1'b1;
                else if (n.len > TB_MAX) n.err = 1'b1;
            end else if (n.bytes > 4 && ((n.bytes - 4) % 4) == 0) begin
                n.pend = 1'b1;
            end
        end else if (s.bytes > 0) begin
            n.idle = s.idle + 1;
            if (TB_TO != 0 && n.idle == int'(TB_TO)) n.err = 1'b1;
        end
        return n;
    endfunction

    // Advance the reference model on every clock edge; reset clears it.
    always @(posedge clk or posedge arst) begin
        if (arst) m <= '0;
        else      m <= modelStep(m, in_valid, in_data, bus_gnt, restart);
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic failBound(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (chk_en && arst === 1'b0) begin
            checkOutput("in_ready", in_ready, !(m.pend || m.done || m.err));
            checkOutput("bus_req", bus_req, m.pend);
            checkOutput("bus_wstrb", bus_wstrb, m.pend ? 4'hF : 4'h0);
            checkOutput("done", done, m.done);
            checkOutput("error", error, m.err);
            checkOutput("core_rst", core_rst, !m.done);
            checkOutput("word_cnt", word_cnt, 32'(m.words));
            if (m.pend) begin
                checkOutput("bus_addr", bus_addr, TB_BASE + 32'(m.words) * 32'd4);
                checkOutput("bus_data", bus_data, m.word);
            end
        end
    end

    // Log bus handshakes and byte acceptances that the coming edge will take.
    always @(negedge clk) begin
        if (arst === 1'b0) begin
            if (bus_req && bus_gnt) begin
                wr_addr.push_back(bus_addr);
                wr_data.push_back(bus_data);
            end
            if (in_valid && in_ready) acc_cnt <= acc_cnt + 1;
        end
    end

    // Random grant generator, active only when a scenario asks for it.
    always @(posedge clk) begin
        #2;
        if (gnt_rand) bus_gnt = 1'($urandom_range(1, 0));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] b, input int maxgap);
        int gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
        int n   = 0;
        repeat (gap) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            restart  = rnd_restart && ($urandom_range(7, 0) == 0);
            tick();
        end
        restart  = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        do begin
            tick();
            n++;
        end while (!m.acc && n < 200);
        if (!m.acc) failBound("byte_accept");
    endtask

    task automatic sendFrame(input logic [31:0] n, input int nw, input int maxgap);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) applyStimulus(n[8*i +: 8], maxgap);
        for (int k = 0; k < nw; k++) begin
            w = img[k];
            for (int i = 0; i < 4; i++) applyStimulus(w[8*i +: 8], maxgap);
        end
        in_valid = 1'b0;
    endtask

    task automatic waitEnd();
        int n = 0;
        in_valid = 1'b0;
        restart  = 1'b0;
        while (!(m.done || m.err) && n < 400) begin
            tick();
            n++;
        end
        if (!(m.done || m.err)) failBound("frame_end");
    endtask

    task automatic restartPulse();
        in_valid = 1'b0;
        restart  = 1'b1;
        tick();
        restart  = 1'b0;
    endtask

    task automatic clearLog();
        wr_addr.delete();
        wr_data.delete();
    endtask

    // Global time limit so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        mismatched++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base;
        int cyc;
        int nlen;
        int nw;

        in_valid = 1'b0;
        in_data  = 8'h00;
        bus_gnt  = 1'b1;
        restart  = 1'b0;
        arst     = 1'b0;
        #1 arst  = 1'b1;
        #1;
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_bus_req", bus_req, 0);
        checkOutput("rst_bus_addr", bus_addr, TB_BASE);
        checkOutput("rst_bus_data", bus_data, 0);
        checkOutput("rst_bus_wstrb", bus_wstrb, 0);
        checkOutput("rst_core_rst", core_rst, 1);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_error", error, 0);
        checkOutput("rst_word_cnt", word_cnt, 0);
        repeat (3) @(posedge clk);
        #1 arst = 1'b0;
        chk_en  = 1'b1;
        tick();

        $display("[TB] basic load");
        clearLog();
        img = '{32'h0010_0FFF, 32'h0000_8103};
        sendFrame(32'd2, 2, 0);
        waitEnd();
        tick();
        checkOutput("basic_writes", wr_data.size(), 2);
        if (wr_data.size() == 2) begin
            checkOutput("basic_addr0", wr_addr[0], 32'h0000_0100);
            checkOutput("basic_data0", wr_data[0], 32'h0010_0FFF);
            checkOutput("basic_addr1", wr_addr[1], 32'h0000_0104);
            checkOutput("basic_data1", wr_data[1], 32'h0000_8103);
        end
        checkOutput("basic_done", done, 1);
        checkOutput("basic_core_rst", core_rst, 0);
        checkOutput("basic_word_cnt", word_cnt, 2);

        restartPulse();
        checkOutput("restart_in_ready", in_ready, 1);
        checkOutput("restart_done", done, 0);
        checkOutput("restart_core_rst", core_rst, 1);
        checkOutput("restart_word_cnt", word_cnt, 0);

        $display("[TB] grant stall");
        clearLog();
        bus_gnt = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(8'(i == 0 ? 2 : 0), 0);
        applyStimulus(8'hFF, 0);
        applyStimulus(8'h0F, 0);
        applyStimulus(8'h10, 0);
        applyStimulus(8'h00, 0);
        in_valid = 1'b0;
        for (int c = 0; c < 7; c++) begin
            checkOutput("stall_req", bus_req, 1);
            checkOutput("stall_addr", bus_addr, 32'h0000_0100);
            checkOutput("stall_data", bus_data, 32'h0010_0FFF);
            checkOutput("stall_in_ready", in_ready, 0);
            tick();
        end
        checkOutput("stall_no_write", wr_data.size(), 0);
        bus_gnt = 1'b1;
        tick();
        checkOutput("stall_one_write", wr_data.size(), 1);
        checkOutput("stall_in_ready_after", in_ready, 1);
        applyStimulus(8'h03, 0);
        applyStimulus(8'h81, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h00, 0);
        waitEnd();
        tick();
        checkOutput("stall_total_writes", wr_data.size(), 2);
        restartPulse();

        $display("[TB] zero and oversize length");
        clearLog();
        sendFrame(32'd0, 0, 0);
        checkOutput("zero_done", done, 1);
        checkOutput("zero_core_rst", core_rst, 0);
        checkOutput("zero_bus_req", bus_req, 0);
        restartPulse();
        sendFrame(32'(TB_MAX + 1), 0, 0);
        checkOutput("over_error", error, 1);
        checkOutput("over_core_rst", core_rst, 1);
        repeat (3) tick();
        checkOutput("over_no_write", wr_data.size(), 0);
        restartPulse();

        $display("[TB] timeout");
        for (int i = 0; i < 4; i++) applyStimulus(8'(i == 0 ? 1 : 0), 0);
        applyStimulus(8'h11, 0);
        applyStimulus(8'h22, 0);
        in_valid = 1'b0;
        cyc = 0;
        while (error !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
        checkOutput("timeout_cycles", cyc, 16);
        restartPulse();
        checkOutput("timeout_restart_error", error, 0);
        checkOutput("timeout_restart_ready", in_ready, 1);
        repeat (40) tick();
        checkOutput("len_idle_no_timeout", error, 0);
        applyStimulus(8'h01, 0);
        in_valid = 1'b0;
        repeat (20) tick();
        checkOutput("len_partial_timeout", error, 1);
        restartPulse();
        clearLog();
        img = '{32'h1234_5678};
        sendFrame(32'd2, 1, 0);
        repeat (30) tick();
        checkOutput("between_words_timeout", error, 1);
        checkOutput("between_words_writes", wr_data.size(), 1);
        restartPulse();

        $display("[TB] reset mid-write");
        bus_gnt = 1'b0;
        img = '{32'h0BAD_F00D};
        sendFrame(32'd1, 1, 0);
        checkOutput("midwr_req_before", bus_req, 1);
        #2 arst = 1'b1;
        #1;
        checkOutput("midwr_req_dropped", bus_req, 0);
        checkOutput("midwr_core_rst", core_rst, 1);
        checkOutput("midwr_word_cnt", word_cnt, 0);
        repeat (2) @(posedge clk);
        #1 arst = 1'b0;
        bus_gnt = 1'b1;
        clearLog();
        img = '{32'hCAFE_F00D};
        sendFrame(32'd1, 1, 0);
        waitEnd();
        tick();
        checkOutput("midwr_reload_writes", wr_data.size(), 1);
        if (wr_data.size() == 1) begin
            checkOutput("midwr_reload_addr", wr_addr[0], TB_BASE);
            checkOutput("midwr_reload_data", wr_data[0], 32'hCAFE_F00D);
        end

        $display("[TB] post-done backpressure and reload");
        base     = acc_cnt;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        repeat (10) tick();
        in_valid = 1'b0;
        tick();
        checkOutput("bp_accepted", acc_cnt - base, 0);
        checkOutput("bp_done", done, 1);
        restartPulse();
        clearLog();
        img = '{32'hDEAD_BEEF};
        sendFrame(32'd1, 1, 0);
        waitEnd();
        tick();
        checkOutput("reload_done", done, 1);
        checkOutput("reload_writes", wr_data.size(), 1);
        if (wr_data.size() == 1) begin
            checkOutput("reload_addr", wr_addr[0], TB_BASE);
            checkOutput("reload_data", wr_data[0], 32'hDEAD_BEEF);
        end
        restartPulse();

        $display("[TB] randomized frames");
        gnt_rand    = 1'b1;
        rnd_restart = 1'b1;
        for (int f = 0; f < 14; f++) begin
            case ($urandom_range(7, 0))
                0:       nlen = 0;
                1:       nlen = int'($urandom_range(20, TB_MAX + 1));
                default: nlen = int'($urandom_range(TB_MAX, 1));
            endcase
            nw = (nlen >= 1 && nlen <= int'(TB_MAX)) ? nlen : 0;
            img.delete();
            for (int k = 0; k < nw; k++) img.push_back($urandom);
            clearLog();
            sendFrame(32'(nlen), nw, 3);
            waitEnd();
            tick();
            if (nlen > int'(TB_MAX)) begin
                checkOutput("rnd_error", error, 1);
                checkOutput("rnd_err_writes", wr_data.size(), 0);
            end else begin
                checkOutput("rnd_done", done, 1);
                checkOutput("rnd_word_cnt", word_cnt, 32'(nlen));
                checkOutput("rnd_writes", wr_data.size(), nw);
                if (wr_data.size() == nw) begin
                    for (int k = 0; k < nw; k++) begin
                        checkOutput("rnd_wr_addr", wr_addr[k], TB_BASE + 32'(4 * k));
                        checkOutput("rnd_wr_data", wr_data[k], img[k]);
                    end
                end
            end
            restartPulse();
        end
        gnt_rand    = 1'b0;
        rnd_restart = 1'b0;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
